// File: rtl/fp_norm_round.sv
// fp_norm_round: post-add normalisation and rounding stage for IEEE-754 single.
// It takes a raw 25-bit sum (carry, hidden bit, fraction) with guard/round/sticky
// bits and produces a packed result. A carry is fixed in one step. A left
// normalisation is done one bit per cycle, and it stops at the subnormal
// boundary. Rounding is round-to-nearest-even, or truncation when ROUND_EN=0.
module fp_norm_round #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SHIFT = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    logic        sign_q;
    logic [8:0]  exp_q;      // one spare bit so that an increment past 8'hFF is visible
    logic [24:0] mant_q;
    logic        g_q;
    logic        r_q;
    logic        s_q;

    // Results of the rounding step. They are used only in S_ROUND.
    logic        round_up;
    logic [24:0] mant_sum;
    logic [8:0]  exp_rnd;
    logic [22:0] frac_rnd;
    logic [31:0] packed_rnd;

    assign in_ready = (state == S_IDLE);

    // Rounding increment, carry renormalisation and overflow-to-infinity packing.
    // NOTE: every signal gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        round_up   = ROUND_EN && g_q && (r_q || s_q || mant_q[0]);
        mant_sum   = mant_q + {24'h0, round_up};
        exp_rnd    = exp_q;
        frac_rnd   = mant_sum[22:0];
        packed_rnd = 32'h0;
        if (mant_sum[24]) begin
            // 1.111..1 rounded up to 10.000..0: renormalise right.
            frac_rnd = mant_sum[23:1];
            exp_rnd  = exp_q + 9'd1;
        end else if ((exp_q == 9'd0) && mant_sum[23]) begin
            // A subnormal rounded up into the hidden bit becomes the smallest normal.
            exp_rnd = 9'd1;
        end
        if (exp_rnd >= 9'h0FF) begin
            packed_rnd = {sign_q, 8'hFF, 23'h0};
        end else begin
            packed_rnd = {sign_q, exp_rnd[7:0], frac_rnd};
        end
    end

    // Control FSM and datapath registers. It uses a synchronous reset, and that reset overrides every state.
    // NOTE: sequential state uses non-blocking (<=) so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= 9'd0;
            mant_q     <= 25'd0;
            g_q        <= 1'b0;
            r_q        <= 1'b0;
            s_q        <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= {1'b0, in_exp};
                        mant_q <= in_mant;
                        g_q    <= in_grs[2];
                        r_q    <= in_grs[1];
                        s_q    <= in_grs[0];
                        state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (mant_q == 25'd0) begin
                        out_result <= {sign_q, 8'h00, 23'h0};
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else if (mant_q[24]) begin
                        // The carry out of the add moves one bit down into the guard bit.
                        mant_q <= {1'b0, mant_q[24:1]};
                        g_q    <= mant_q[0];
                        r_q    <= g_q;
                        s_q    <= r_q | s_q;
                        exp_q  <= exp_q + 9'd1;
                        state  <= S_ROUND;
                    end else if (mant_q[23]) begin
                        state <= S_ROUND;
                    end else begin
                        state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (exp_q < 9'd2) begin
                        // Another shift would take the exponent to zero.
                        // Stop here as a subnormal and leave the mantissa unshifted.
                        exp_q <= 9'd0;
                        state <= S_ROUND;
                    end else begin
                        mant_q <= {mant_q[23:0], g_q};
                        g_q    <= r_q;
                        r_q    <= 1'b0;
                        exp_q  <= exp_q - 9'd1;
                        if (mant_q[22]) begin
                            state <= S_ROUND;
                        end
                    end
                end

                S_ROUND: begin
                    out_result <= packed_rnd;
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed vectors, applied to two copies of the block.
// One copy rounds to nearest even and the other truncates. Both copies share the same stimulus.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_ready;

    logic        in_ready,   out_valid;
    logic [31:0] out_result;
    logic        in_ready_t, out_valid_t;
    logic [31:0] out_result_t;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fp_norm_round #(.ROUND_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    fp_norm_round #(.ROUND_EN(1'b0)) dut_t (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_t),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_result(out_result_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input, check latency and both results, then optionally stall in DONE.
    task automatic run(input string tag, input logic sgn, input logic [7:0] e,
                       input logic [24:0] m, input logic [2:0] grs,
                       input logic [31:0] exp_rne, input logic [31:0] exp_trn,
                       input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        check({tag, "/in_ready_before"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_sign   = sgn;
        in_exp    = e;
        in_mant   = m;
        in_grs    = grs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 64 && !out_valid) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/valid_trunc"}, 32'(out_valid_t), 32'd1);
        check({tag, "/result_rne"}, out_result, exp_rne);
        check({tag, "/result_trunc"}, out_result_t, exp_trn);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_result"}, out_result, exp_rne);
            check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "/valid_after"}, 32'(out_valid), 32'd0);
        check({tag, "/in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 25'h0;
        in_grs    = 3'b000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out_result", out_result, 32'h0);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Carry renormalisation, the exact case and the tie case, overflow, and signed zero.
        run("carry",     1'b0, 8'h7F, 25'h1000000, 3'b000, 32'h40000000, 32'h40000000, 3, 0);
        run("shift23",   1'b0, 8'h7F, 25'h0000001, 3'b000, 32'h34000000, 32'h34000000, 26, 0);
        run("tie_odd",   1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 32'h40000000, 32'h3FFFFFFF, 3, 0);
        run("overflow",  1'b0, 8'hFE, 25'h1000000, 3'b000, 32'h7F800000, 32'h7F800000, 3, 0);
        run("neg_zero",  1'b1, 8'h7F, 25'h0000000, 3'b000, 32'h80000000, 32'h80000000, 2, 0);
        // Rounding cases. The even tie stays put, above half rounds up, and the carry path uses the guard bit.
        run("tie_lsb1",  1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800002, 32'h3F800001, 3, 0);
        run("gr_up",     1'b0, 8'h7F, 25'h0800000, 3'b110, 32'h3F800001, 32'h3F800000, 3, 0);
        run("tie_even",  1'b0, 8'h7F, 25'h0800000, 3'b100, 32'h3F800000, 32'h3F800000, 3, 0);
        run("carry_grs", 1'b0, 8'h7F, 25'h1000003, 3'b000, 32'h40000002, 32'h40000001, 3, 0);
        // A guard bit shifts into the LSB during normalisation.
        run("shift_g",   1'b0, 8'h7F, 25'h0400000, 3'b100, 32'h3F000001, 32'h3F000001, 4, 0);
        // Subnormal stop, and a subnormal that rounds up into the smallest normal.
        run("subnorm",   1'b0, 8'h03, 25'h0000001, 3'b000, 32'h00000004, 32'h00000004, 6, 0);
        run("sub_round", 1'b0, 8'h01, 25'h07FFFFF, 3'b110, 32'h00800000, 32'h007FFFFF, 4, 0);
        // Back-pressure: the block stalls in DONE for 5 cycles.
        run("hold",      1'b1, 8'h80, 25'h0C00000, 3'b000, 32'hC0400000, 32'hC0400000, 3, 5);

        // Reset in the middle of SHIFT throws the result away.
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'h7F;
        in_mant  = 25'h0000001;
        in_grs   = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/out_result", out_result, 32'h0);
        check("midrst/in_ready", 32'(in_ready), 32'd1);
        run("after_rst", 1'b0, 8'h7F, 25'h1000000, 3'b000, 32'h40000000, 32'h40000000, 3, 0);

        // When rst and in_valid are high together, the input must not be captured.
        @(negedge clk);
        out_ready = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_exp    = 8'h7F;
        in_mant   = 25'h1000000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid/in_ready", 32'(in_ready), 32'd1);
        end
        check("rst_valid/out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have parameter: ROUND_EN, 1, 1 = round-to-nearest-even, 0 = truncate (guard/round/sticky ignored).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  raw adder result present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a raw result.
REQ-006 SHALL have port: in_sign  input  1  result sign.
REQ-007 SHALL have port: in_exp  input  8  biased exponent of the larger operand.
REQ-008 SHALL have port: in_mant  input  25  raw sum, with [24] = carry, [23] = hidden bit and [22:0] = fraction.
REQ-009 SHALL have port: in_grs  input  3  guard, round, sticky bits from the alignment shift.
REQ-010 SHALL have port: out_valid  output  1  packed IEEE-754 single result valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: out_result  output  32  {sign, exp[7:0], frac[22:0]}.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, SHIFT, ROUND, DONE; in_ready SHALL equal (state==IDLE).
REQ-014 IDLE: on in_valid && in_ready, SHALL register sign/exp/mant/grs and go to CHECK; otherwise SHALL stay in IDLE.
REQ-015 CHECK, mant==0: SHALL set result to {sign, 8'h00, 23'h0} and go to DONE.
REQ-016 CHECK, mant[24]==1: SHALL shift mant right 1, set new guard = old mant[0], new round = old guard, new sticky = old round|old sticky, increment exp, and go to ROUND.
REQ-017 CHECK, mant[24:23]==2'b01: SHALL go to ROUND unchanged.
REQ-018 CHECK, mant[24:23]==2'b00: SHALL go to SHIFT.
REQ-019 SHIFT: each cycle SHALL shift mant left 1 with guard shifted into mant[0], shift round into guard, clear round, hold sticky, and decrement exp.
REQ-020 SHIFT exit: SHALL go to ROUND when the new mant[23]==1, or when exp would drop to 0; in the latter case SHALL set exp=0 and hold mant unshifted (subnormal).
REQ-021 SHIFT SHALL last at most 23 cycles.
REQ-022 ROUND, ROUND_EN=1: SHALL increment mant when guard && (round || sticky || mant[0]).
REQ-023 ROUND: if the increment carries into mant[24], SHALL shift right 1 and increment exp; a subnormal rounding into mant[23] SHALL set exp=1.
REQ-024 ROUND: if the final exp >= 8'hFF, SHALL set result to {sign, 8'hFF, 23'h0} (infinity); otherwise {sign, exp, mant[22:0]}; then go to DONE.
REQ-025 Exponent arithmetic SHALL be 9-bit internally so that increment overflow is detected and never wraps.
REQ-026 DONE: out_valid=1 and out_result SHALL be held stable until out_ready; on out_valid && out_ready SHALL go to IDLE.
REQ-027 SHALL NOT accept a new input in the cycle the result is consumed (in_ready rises the following cycle).
REQ-028 Latency from accept edge to out_valid SHALL be 3 cycles plus the SHIFT cycle count.
REQ-029 out_result SHALL change only when entering DONE.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, out_valid=0, out_result=32'h0, in_ready=1 after that edge, and all internal registers cleared.
REQ-031 rst SHALL override every state, including mid-SHIFT and DONE with out_ready=0; any in-flight result is discarded.
REQ-032 rst and in_valid high together: the input SHALL NOT be captured.

Verification
REQ-033 in_mant=25'h1000000, in_exp=8'h7F, grs=0, out_ready=1 -> out_result=32'h40000000, out_valid 3 cycles after accept.
REQ-034 in_mant=25'h0000001, in_exp=8'h7F, grs=0 -> 23 SHIFT cycles, out_result=32'h34000000, out_valid 26 cycles after accept.
REQ-035 in_mant=25'h0FFFFFF, in_exp=8'h7F, grs=3'b100, ROUND_EN=1 -> tie, LSB odd, rounds up and renormalizes to 32'h40000000; with ROUND_EN=0 -> 32'h3FFFFFFF.
REQ-036 in_mant=25'h1000000, in_exp=8'hFE -> 32'h7F800000; in_mant=0, in_sign=1 -> 32'h80000000.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_result stable and in_ready=0 throughout; release -> one transfer, then in_ready=1 next cycle.
REQ-038 Assert rst during SHIFT of the REQ-034 case -> next cycle out_valid=0, out_result=0, in_ready=1; a fresh REQ-033 input then completes normally.
